spike_rate_encoder: RTL and testbench

Converts multi-channel intensity values (pixels) into spike trains that drive the input_spike pins of the LIF neuron array. Each accepted input vector becomes one frame of WINDOW timesteps. Each channel emits single-cycle spike pulses at a rate proportional to its intensity. Supports a deterministic phase-accumulator mode and a stochastic LFSR (Bernoulli/Poisson-like) mode.

---
 rtl/neuron_pkg.sv | 17 +
 rtl/spike_lfsr.sv | 38 +++
 rtl/spike_rate_encoder.sv | 127 ++++++++++++
 tb/tb_spike_rate_encoder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the spiking-network front end.
package neuron_pkg;

    localparam int ENC_PIX_W = 8;

    typedef logic [ENC_PIX_W-1:0] pixel_t;

    typedef enum logic {
        ENC_IDLE,
        ENC_ENCODE
    } enc_state_t;

    // x^16 + x^14 + x^13 + x^11, Galois form, right-shifting.
    localparam logic [15:0] ENC_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] ENC_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/spike_lfsr.sv
// Right-shifting Galois LFSR with enable and reset seed.
// Used as the shared random source for stochastic spike generation.
module spike_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Next state: shift right, fold taps in when the bit shifted out is 1.
    always_comb begin
        // NOTE: default assignment first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        if (en_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        end
    end

    // State register, reset to the (nonzero) seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            // NOTE: non-blocking assignment so all flops update together at the edge.
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns one vector of channel intensities into a frame of
// WINDOW timesteps of single-cycle spikes, using either a deterministic
// phase accumulator or a comparison against a shared LFSR.
module spike_rate_encoder
    import neuron_pkg::*;
#(
    parameter int                NUM_CH    = 4,
    parameter int                PIX_W     = 8,
    parameter int                WINDOW    = 16,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(ENC_LFSR_SEED),
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(ENC_LFSR_TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*PIX_W-1:0] in_pixel,
    input  logic                    in_mode,
    input  logic                    step_en,
    output logic [NUM_CH-1:0]       spike_out,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int               CNT_W     = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WINDOW - 1);

    enc_state_t              state_q;
    logic [NUM_CH*PIX_W-1:0] pix_q;
    logic                    mode_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_CH-1:0]       spike_q;
    logic [NUM_CH-1:0]       spike_d;
    logic                    done_q;
    logic                    accept;
    logic                    step;
    logic [LFSR_W-1:0]       lfsr;

    assign in_ready   = (state_q == ENC_IDLE);
    assign busy       = (state_q == ENC_ENCODE);
    assign accept     = in_valid & in_ready;
    // Strobes outside a frame (including the accept cycle) are ignored.
    assign step       = busy & step_en;
    assign spike_out  = spike_q;
    assign frame_done = done_q;

    // All channels sample the same pre-advance LFSR value on a step.
    spike_lfsr #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (step),
        .state_o (lfsr)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Each channel sees the LFSR rotated by a different amount so the
        // channels do not compare against identical random values.
        localparam int ROT = (3 * c) % LFSR_W;

        logic [PIX_W-1:0] pix;
        logic [PIX_W-1:0] acc_q;
        logic [PIX_W-1:0] rnd;
        logic [PIX_W:0]   sum;

        assign pix = pix_q[c*PIX_W +: PIX_W];
        assign sum = {1'b0, acc_q} + {1'b0, pix};
        assign rnd = PIX_W'({lfsr, lfsr} >> ROT);

        // Accumulator carry-out is the deterministic spike; LFSR compare is the stochastic one.
        assign spike_d[c] = mode_q ? (rnd < pix) : sum[PIX_W];

        // Phase accumulator: cleared on accept, advanced on deterministic steps.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
            end else if (accept) begin
                acc_q <= '0;
            end else if (step && !mode_q) begin
                acc_q <= sum[PIX_W-1:0];
            end
        end
    end

    // Frame control FSM with registered spike and frame_done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENC_IDLE;
            pix_q   <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            spike_q <= '0;
            done_q  <= 1'b0;
        end else begin
            spike_q <= '0;
            done_q  <= 1'b0;
            case (state_q)
                ENC_IDLE: begin
                    if (in_valid) begin
                        pix_q   <= in_pixel;
                        mode_q  <= in_mode;
                        cnt_q   <= '0;
                        state_q <= ENC_ENCODE;
                    end
                end
                ENC_ENCODE: begin
                    if (step_en) begin
                        spike_q <= spike_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        // Returning to IDLE here lets the next vector be
                        // accepted in the frame_done cycle.
                        if (cnt_q == LAST_STEP) begin
                            done_q  <= 1'b1;
                            state_q <= ENC_IDLE;
                        end
                    end
                end
                default: state_q <= ENC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: the driver pushes expected
// per-step spikes and per-frame spike counts; a negedge monitor pops them.
module tb_spike_rate_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pixel;
    logic        in_mode;
    logic        step_en;
    logic [3:0]  spike_out;
    logic        busy;
    logic        frame_done;

    spike_rate_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_mode    (in_mode),
        .step_en    (step_en),
        .spike_out  (spike_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [3:0] spk;
        logic       done;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cnt_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic        m_busy;
    logic [31:0] m_pix;
    logic        m_mode;
    logic [7:0]  m_acc [4];
    int          m_cnt;
    int          m_cnts [4];
    logic [31:0] m_hand;
    logic        m_use_hand;
    logic [31:0] next_hand;
    logic        next_use_hand;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] n;
        n = x >> 1;
        if (x[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [15:0] rotr(input logic [15:0] x, input int n);
        if (n == 0) return x;
        return (x >> n) | (x << (16 - n));
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_busy = 1'b0;
        m_pix  = '0;
        m_mode = 1'b0;
        m_cnt  = 0;
        for (int c = 0; c < 4; c++) begin
            m_acc[c]  = '0;
            m_cnts[c] = 0;
        end
    endtask

    // One clock of stimulus; the model mirrors what the DUT does at the coming posedge.
    task automatic cycle(input logic v, input logic [31:0] pix, input logic md, input logic st);
        exp_t        e;
        logic [8:0]  sum;
        logic [15:0] r;
        logic [7:0]  p;
        logic [31:0] cv;
        in_valid = v;
        in_pixel = pix;
        in_mode  = md;
        step_en  = st;
        check("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        check("busy",     {31'd0, busy},     {31'd0, m_busy});
        if (m_busy && st) begin
            for (int c = 0; c < 4; c++) begin
                p = m_pix[c*8 +: 8];
                if (m_mode) begin
                    r = rotr(m_lfsr, 3 * c);
                    e.spk[c] = (r[7:0] < p);
                end else begin
                    sum = {1'b0, m_acc[c]} + {1'b0, p};
                    m_acc[c] = sum[7:0];
                    e.spk[c] = sum[8];
                end
                m_cnts[c] += int'(e.spk[c]);
            end
            m_lfsr = lfsr_next(m_lfsr);
            m_cnt++;
            e.done = (m_cnt == 16);
            e.due  = cyc + 1;
            exp_q.push_back(e);
            if (e.done) begin
                for (int c = 0; c < 4; c++) cv[c*8 +: 8] = 8'(m_cnts[c]);
                cnt_q.push_back(m_use_hand ? m_hand : cv);
                m_busy = 1'b0;
            end
        end else if (!m_busy && v) begin
            m_pix      = pix;
            m_mode     = md;
            m_cnt      = 0;
            m_hand     = next_hand;
            m_use_hand = next_use_hand;
            for (int c = 0; c < 4; c++) begin
                m_acc[c]  = '0;
                m_cnts[c] = 0;
            end
            m_busy = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [31:0] pix, input logic md,
                             input logic [31:0] hand, input logic use_hand);
        next_hand     = hand;
        next_use_hand = use_hand;
        cycle(1'b1, pix, md, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, pix, md, 1'b1);
    endtask

    // ---------------- monitor ----------------
    int obs [4];

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ec;
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) obs[c] = 0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                check("spike_out",  {28'd0, spike_out},  {28'd0, e.spk});
                check("frame_done", {31'd0, frame_done}, {31'd0, e.done});
            end else begin
                check("spike_quiet", {28'd0, spike_out},  32'd0);
                check("done_quiet",  {31'd0, frame_done}, 32'd0);
            end
            for (int c = 0; c < 4; c++) obs[c] += int'(spike_out[c]);
            if (frame_done) begin
                if (cnt_q.size() == 0) begin
                    check("unexpected_frame_done", 32'd1, 32'd0);
                end else begin
                    ec = cnt_q.pop_front();
                    for (int c = 0; c < 4; c++)
                        check($sformatf("frame_count_ch%0d", c), 32'(obs[c]), {24'd0, ec[c*8 +: 8]});
                end
                for (int c = 0; c < 4; c++) obs[c] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pa;
        logic [31:0] pb;
        int          strobes;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_pixel      = '0;
        in_mode       = 1'b0;
        step_en       = 1'b0;
        next_hand     = '0;
        next_use_hand = 1'b0;
        model_reset();

        #1;
        check("rst_in_ready",   {31'd0, in_ready},   32'd1);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_spike_out",  {28'd0, spike_out},  32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        #21 rst_n = 1'b1;
        @(negedge clk);

        // Strobes while idle: no spikes, no LFSR advance.
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Deterministic: {0,64,128,255} -> {0,4,8,15}.
        run_frame({8'd255, 8'd128, 8'd64, 8'd0}, 1'b0, {8'd15, 8'd8, 8'd4, 8'd0}, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Stochastic: {0,255,128,32}; counts from the LFSR model.
        run_frame({8'd32, 8'd128, 8'd255, 8'd0}, 1'b1, '0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Handshake: B held valid during A, accepted in A's frame_done cycle.
        pa = {8'd1, 8'd16, 8'd32, 8'd255};   // counts {15,2,1,0}
        pb = {8'd192, 8'd64, 8'd0, 8'd128};  // counts {8,0,4,12}
        next_hand     = {8'd0, 8'd1, 8'd2, 8'd15};
        next_use_hand = 1'b1;
        cycle(1'b1, pa, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, pa, 1'b0, 1'b1);
        next_hand = {8'd12, 8'd4, 8'd0, 8'd8};
        for (int i = 0; i < 8; i++) cycle(1'b1, pb, 1'b0, 1'b1);
        cycle(1'b1, pb, 1'b0, 1'b1);         // accept cycle, strobe ignored
        for (int i = 0; i < 16; i++) cycle(1'b0, pb, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Sparse strobes: {25,50,100,200} -> {1,3,6,12}.
        next_hand     = {8'd1, 8'd3, 8'd6, 8'd12};
        next_use_hand = 1'b1;
        pa = {8'd25, 8'd50, 8'd100, 8'd200};
        cycle(1'b1, pa, 1'b0, 1'b0);
        strobes = 0;
        while (strobes < 16) begin
            int gap;
            gap = int'($urandom_range(0, 6));
            for (int g = 0; g < gap; g++) cycle(1'b0, pa, 1'b0, 1'b0);
            cycle(1'b0, pa, 1'b0, 1'b1);
            strobes++;
        end
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Reset after step 7 of a frame.
        pa = {4{8'd128}};
        cycle(1'b1, pa, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, pa, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_spike_out",  {28'd0, spike_out},  32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        check("midrst_busy",       {31'd0, busy},       32'd0);
        check("midrst_in_ready",   {31'd0, in_ready},   32'd1);
        exp_q.delete();
        cnt_q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_frame(pa, 1'b0, {4{8'd8}}, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        // LFSR restarted from the seed after reset.
        run_frame({8'd32, 8'd128, 8'd255, 8'd0}, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("cnt_queue_drained", 32'(cnt_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
